// File: rtl/ex_stall_ctrl.sv
// rtl/ex_stall_ctrl.sv - pipeline stall controller and multi-cycle EX sequencer
// Merges ID load-use and EX multi-cycle stalls; counts madd/div cycles for EX.
module ex_stall_ctrl #(
  parameter int MADD_CYCLES = 2,
  parameter int DIV_CYCLES  = 32,
  parameter int CNT_W       = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stallreq_id,
  input  logic             ex_op_start,
  input  logic [1:0]       ex_op_kind,
  input  logic             flush,
  output logic [5:0]       stall,
  output logic             ex_mem_bubble,
  output logic [CNT_W-1:0] ex_cnt,
  output logic             ex_done,
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] N_MADD = CNT_W'(MADD_CYCLES);
  localparam logic [CNT_W-1:0] N_DIV  = CNT_W'(DIV_CYCLES);

  localparam logic [5:0] STALL_EX   = 6'b001111;
  localparam logic [5:0] STALL_ID   = 6'b000111;
  localparam logic [5:0] STALL_NONE = 6'b000000;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] n_q;
  logic [CNT_W-1:0] n_d;
  logic             start_ok;
  logic             ex_stall;
  logic             last_cycle;

  assign start_ok   = (state_q == S_IDLE) && ex_op_start && (ex_op_kind != 2'b00);
  assign ex_stall   = start_ok || (state_q == S_RUN);
  assign last_cycle = (cnt_q == (n_q - 1'b1));
  assign n_d        = (ex_op_kind == 2'b01) ? N_MADD : N_DIV;

  // Outputs are gated by reset and flush so nothing reaches the pipeline regs.
  always_comb begin
    stall         = STALL_NONE;
    ex_mem_bubble = 1'b0;
    ex_done       = 1'b0;
    busy          = 1'b0;
    if (rst) begin
      busy = (state_q != S_IDLE);
      if (flush) begin
        ex_mem_bubble = 1'b1;
      end else begin
        if (ex_stall) begin
          stall = STALL_EX;
        end else if (stallreq_id) begin
          stall = STALL_ID;
        end
        ex_mem_bubble = stall[3] & ~stall[4];
        ex_done       = (state_q == S_DONE);
      end
    end
  end

  assign ex_cnt = cnt_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      n_q     <= '0;
    end else if (flush) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_ok) begin
            state_q <= S_RUN;
            cnt_q   <= CNT_W'(1);
            n_q     <= n_d;
          end
        end
        S_RUN: begin
          if (last_cycle) begin
            state_q <= S_DONE;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          cnt_q   <= '0;
        end
        default: begin
          state_q <= S_IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ex_stall_ctrl.sv
// tb/tb_ex_stall_ctrl.sv - directed table-driven bench for ex_stall_ctrl
module tb_ex_stall_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       stallreq_id;
  logic       ex_op_start;
  logic [1:0] ex_op_kind;
  logic       flush;
  logic [5:0] stall;
  logic       ex_mem_bubble;
  logic [5:0] ex_cnt;
  logic       ex_done;
  logic       busy;

  int checks = 0;
  int errors = 0;

  ex_stall_ctrl #(.MADD_CYCLES(2), .DIV_CYCLES(32), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .stallreq_id(stallreq_id), .ex_op_start(ex_op_start),
    .ex_op_kind(ex_op_kind), .flush(flush), .stall(stall), .ex_mem_bubble(ex_mem_bubble),
    .ex_cnt(ex_cnt), .ex_done(ex_done), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       sid;
    logic       start;
    logic [1:0] kind;
    logic       flush;
    logic [5:0] stall;
    logic       bub;
    logic [5:0] cnt;
    logic       done;
    logic       busy;
  } vec_t;

  vec_t vt[24];

  function automatic vec_t mk(logic r, logic s, logic st, logic [1:0] k, logic f,
                              logic [5:0] es, logic eb, logic [5:0] ec, logic ed, logic ebz);
    vec_t v;
    v.rst = r; v.sid = s; v.start = st; v.kind = k; v.flush = f;
    v.stall = es; v.bub = eb; v.cnt = ec; v.done = ed; v.busy = ebz;
    return v;
  endfunction

  task automatic drive(logic r, logic s, logic st, logic [1:0] k, logic f);
    rst = r; stallreq_id = s; ex_op_start = st; ex_op_kind = k; flush = f;
  endtask

  task automatic chk(string name, int idx, logic [5:0] got, logic [5:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s @%0d: got %0h expected %0h", name, idx, got, exp);
    end
  endtask

  task automatic check_all(string tag, int idx, logic [5:0] es, logic eb,
                           logic [5:0] ec, logic ed, logic ebz);
    @(negedge clk);
    chk({tag, ".stall"}, idx, stall, es);
    chk({tag, ".bubble"}, idx, {5'd0, ex_mem_bubble}, {5'd0, eb});
    chk({tag, ".ex_cnt"}, idx, ex_cnt, ec);
    chk({tag, ".ex_done"}, idx, {5'd0, ex_done}, {5'd0, ed});
    chk({tag, ".busy"}, idx, {5'd0, busy}, {5'd0, ebz});
    @(posedge clk);
    #1;
  endtask

  // Runs a div/divu from IDLE; optional ID stall and flush at given offsets.
  task automatic run_div(string tag, logic [1:0] kind, int sid_at, int flush_at);
    logic seen_done;
    for (int i = 0; i < 32; i++) begin
      if (i == flush_at) begin
        drive(1, 0, 1, kind, 1);
        check_all(tag, i, 6'h00, 1, 6'(i), 0, 1);
        seen_done = 0;
        for (int j = 0; j < 40; j++) begin
          drive(1, 0, 0, 2'b00, 0);
          @(negedge clk);
          if (j == 0) begin
            chk({tag, ".post_flush_cnt"}, j, ex_cnt, 6'd0);
            chk({tag, ".post_flush_busy"}, j, {5'd0, busy}, 6'd0);
          end
          if (ex_done) seen_done = 1;
          @(posedge clk);
          #1;
        end
        chk({tag, ".no_done_after_flush"}, 0, {5'd0, seen_done}, 6'd0);
        return;
      end
      drive(1, (i == sid_at), 1, kind, 0);
      check_all(tag, i, 6'h0F, 1, 6'(i), 0, (i != 0));
    end
    drive(1, 0, 1, kind, 0);
    check_all(tag, 32, 6'h00, 0, 6'd0, 1, 1);
    drive(1, 0, 0, 2'b00, 0);
    check_all(tag, 33, 6'h00, 0, 6'd0, 0, 0);
  endtask

  initial begin
    // r sid st kind fl | stall bub cnt done busy
    vt[0]  = mk(0, 0, 0, 2'b00, 0, 6'h00, 0, 6'd0, 0, 0);
    vt[1]  = mk(1, 0, 0, 2'b00, 0, 6'h00, 0, 6'd0, 0, 0);
    vt[2]  = mk(1, 1, 0, 2'b00, 0, 6'h07, 0, 6'd0, 0, 0);
    vt[3]  = mk(1, 0, 0, 2'b00, 0, 6'h00, 0, 6'd0, 0, 0);
    vt[4]  = mk(1, 0, 1, 2'b01, 0, 6'h0F, 1, 6'd0, 0, 0);
    vt[5]  = mk(1, 0, 1, 2'b01, 0, 6'h0F, 1, 6'd1, 0, 1);
    vt[6]  = mk(1, 0, 1, 2'b01, 0, 6'h00, 0, 6'd0, 1, 1);
    vt[7]  = mk(1, 0, 0, 2'b00, 0, 6'h00, 0, 6'd0, 0, 0);
    vt[8]  = mk(1, 1, 1, 2'b01, 0, 6'h0F, 1, 6'd0, 0, 0);
    vt[9]  = mk(1, 1, 1, 2'b01, 1, 6'h00, 1, 6'd1, 0, 1);
    vt[10] = mk(1, 0, 1, 2'b00, 0, 6'h00, 0, 6'd0, 0, 0);
    vt[11] = mk(1, 0, 0, 2'b00, 1, 6'h00, 1, 6'd0, 0, 0);
    vt[12] = mk(1, 1, 0, 2'b00, 1, 6'h00, 1, 6'd0, 0, 0);
    vt[13] = mk(1, 0, 1, 2'b01, 0, 6'h0F, 1, 6'd0, 0, 0);
    vt[14] = mk(0, 0, 1, 2'b01, 0, 6'h00, 0, 6'd1, 0, 0);
    vt[15] = mk(1, 0, 0, 2'b00, 0, 6'h00, 0, 6'd0, 0, 0);
    vt[16] = mk(1, 0, 1, 2'b01, 0, 6'h0F, 1, 6'd0, 0, 0);
    vt[17] = mk(1, 0, 1, 2'b10, 0, 6'h0F, 1, 6'd1, 0, 1);
    vt[18] = mk(1, 0, 1, 2'b10, 0, 6'h00, 0, 6'd0, 1, 1);
    vt[19] = mk(1, 0, 0, 2'b00, 0, 6'h00, 0, 6'd0, 0, 0);
    vt[20] = mk(1, 0, 1, 2'b01, 0, 6'h0F, 1, 6'd0, 0, 0);
    vt[21] = mk(1, 0, 1, 2'b01, 0, 6'h0F, 1, 6'd1, 0, 1);
    vt[22] = mk(1, 0, 0, 2'b00, 1, 6'h00, 1, 6'd0, 0, 1);
    vt[23] = mk(1, 0, 0, 2'b00, 0, 6'h00, 0, 6'd0, 0, 0);

    drive(0, 0, 0, 2'b00, 0);
    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < 24; i++) begin
      drive(vt[i].rst, vt[i].sid, vt[i].start, vt[i].kind, vt[i].flush);
      check_all("vec", i, vt[i].stall, vt[i].bub, vt[i].cnt, vt[i].done, vt[i].busy);
    end

    run_div("div", 2'b10, 5, -1);
    run_div("div_flush", 2'b11, -1, 10);

    drive(1, 0, 1, 2'b01, 0);
    check_all("rst_madd", 0, 6'h0F, 1, 6'd0, 0, 0);
    drive(1, 0, 1, 2'b01, 0);
    check_all("rst_madd", 1, 6'h0F, 1, 6'd1, 0, 1);
    drive(0, 0, 1, 2'b01, 0);
    check_all("rst_madd", 2, 6'h00, 0, 6'd0, 0, 0);
    run_div("div_after_rst", 2'b10, -1, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
